mux2a1class_arb: RTL and testbench

//  - Merges the two class streams (class 0, class 1) back into one 10-bit word stream.
//  - Sits after the per-class queues, at the output of the classification path.
//  - Word format: [9] valid, [8] class, [7:0] payload.
//  - Class 0 has priority; a starvation limit guarantees class-1 service; output is registered.

---
 rtl/class_pkg.sv | 23 ++
 rtl/class_arb_fsm.sv | 53 +++++
 rtl/mux2a1class_arb.sv | 77 +++++++
 tb/tb_mux2a1class_arb.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/class_pkg.sv
// Shared word layout, FSM state encoding and word-building helper for the
// class-merge arbiter.
package class_pkg;

   localparam int WORD_W    = 10;
   localparam int VALID_BIT = 9;
   localparam int CLASS_BIT = 8;
   localparam int PAYLOAD_W = 8;
   localparam int CONSEC_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_C0   = 2'd1,
      ST_C1   = 2'd2
   } arb_state_e;

   // The incoming class bit is discarded; the source port defines the class.
   function automatic logic [WORD_W-1:0] make_word(input logic cls,
                                                   input logic [WORD_W-1:0] word);
      return {1'b1, cls, word[PAYLOAD_W-1:0]};
   endfunction

endpackage

// File: rtl/class_arb_fsm.sv
// Arbitration state machine: tracks the last grant and the run of class-0
// grants taken while class 1 waits, and decides which class wins this cycle.
module class_arb_fsm
   import class_pkg::*;
#(
   parameter int MAX_CONSEC0 = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic req0,
   input  logic req1,
   output logic grant0,
   output logic grant1
);

   localparam logic [CONSEC_W-1:0] MAX_C = CONSEC_W'(MAX_CONSEC0);

   arb_state_e          state;
   logic [CONSEC_W-1:0] consec0;
   logic [CONSEC_W-1:0] consec_eff;

   // A class-0 run only exists while the last grant went to class 0.
   always_comb begin
      consec_eff = (state == ST_C0) ? consec0 : '0;
      grant1     = req1 && (!req0 || (consec_eff >= MAX_C));
      grant0     = req0 && !grant1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         consec0 <= '0;
      end else if (load) begin
         if (grant1) begin
            state   <= ST_C1;
            consec0 <= '0;
         end else if (grant0) begin
            state <= ST_C0;
            if (!req1)
               consec0 <= '0;
            else if (consec_eff < MAX_C)
               consec0 <= consec_eff + 1'b1;
            else
               consec0 <= MAX_C;
         end else begin
            state   <= ST_IDLE;
            consec0 <= '0;
         end
      end
   end

endmodule

// File: rtl/mux2a1class_arb.sv
// Merges the class-0 and class-1 head words into one registered output stream.
// Optional per-class grant counters are built when ARB_STATS_EN is defined.
module mux2a1class_arb
   import class_pkg::*;
#(
   parameter int MAX_CONSEC0 = 4
`ifdef ARB_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] in_class0,
   input  logic [WORD_W-1:0] in_class1,
   output logic              pop_class0,
   output logic              pop_class1,
   input  logic              out_ready,
   output logic [WORD_W-1:0] dataout
`ifdef ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
`endif
);

   logic load;
   logic grant0;
   logic grant1;

   class_arb_fsm #(
      .MAX_CONSEC0(MAX_CONSEC0)
   ) u_fsm (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .req0  (in_class0[VALID_BIT]),
      .req1  (in_class1[VALID_BIT]),
      .grant0(grant0),
      .grant1(grant1)
   );

   // Pops are masked by reset so a queue never advances while the slot is cleared.
   always_comb begin
      load       = !dataout[VALID_BIT] || out_ready;
      pop_class0 = load && grant0 && !reset;
      pop_class1 = load && grant1 && !reset;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         dataout <= '0;
      else if (load) begin
         if (pop_class1)
            dataout <= make_word(1'b1, in_class1);
         else if (pop_class0)
            dataout <= make_word(1'b0, in_class0);
         else
            dataout <= '0;
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (pop_class0)
            grant_cnt0 <= grant_cnt0 + 1'b1;
         if (pop_class1)
            grant_cnt1 <= grant_cnt1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mux2a1class_arb.sv
// Scoreboard bench for mux2a1class_arb; define ARB_STATS_EN to also check the
// wrapping grant counters with CNT_W=4.
module tb_mux2a1class_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] in_class0;
   logic [9:0] in_class1;
   logic       pop_class0;
   logic       pop_class1;
   logic       out_ready;
   logic [9:0] dataout;
`ifdef ARB_STATS_EN
   logic [3:0] grant_cnt0;
   logic [3:0] grant_cnt1;
`endif

   int total = 0;
   int bad   = 0;
   logic [9:0] sb[$];

   always #5 clk = ~clk;

   mux2a1class_arb #(
      .MAX_CONSEC0(4)
`ifdef ARB_STATS_EN
      ,
      .CNT_W(4)
`endif
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_class0 (in_class0),
      .in_class1 (in_class1),
      .pop_class0(pop_class0),
      .pop_class1(pop_class1),
      .out_ready (out_ready),
      .dataout   (dataout)
`ifdef ARB_STATS_EN
      ,
      .grant_cnt0(grant_cnt0),
      .grant_cnt1(grant_cnt1)
`endif
   );

   task automatic checkOutput(input string name, input logic [9:0] actual,
                              input logic [9:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h", name, actual, expected);
      end
   endtask

   // Drives one cycle from posedge+1, checks the combinational pops mid-cycle and
   // queues the word the monitor should see once the slot is consumed.
   task automatic applyStimulus(input logic [9:0] c0, input logic [9:0] c1,
                                input logic rdy, input logic exp_pop0,
                                input logic exp_pop1, input logic [9:0] exp_word,
                                input logic push);
      in_class0 = c0;
      in_class1 = c1;
      out_ready = rdy;
      #2;
      checkOutput("pop_class0", {9'd0, pop_class0}, {9'd0, exp_pop0});
      checkOutput("pop_class1", {9'd0, pop_class1}, {9'd0, exp_pop1});
      if (push)
         sb.push_back(exp_word);
      @(posedge clk);
      #1;
   endtask

   // Monitor: a valid word with out_ready high at the negedge is consumed next edge.
   always @(negedge clk) begin
      if (!reset && dataout[9] && out_ready) begin
         if (sb.size() == 0)
            checkOutput("unexpected_word", dataout, 10'h000);
         else
            checkOutput("dataout", dataout, sb.pop_front());
      end
   end

   initial begin
      logic [9:0] cls_seq;
      logic [9:0] w;
      cls_seq   = 10'b10000_10000;
      reset     = 1'b1;
      in_class0 = '0;
      in_class1 = '0;
      out_ready = 1'b0;
      #3;
      checkOutput("reset_dataout", dataout, 10'h000);
      checkOutput("reset_pops", {8'd0, pop_class0, pop_class1}, 10'h000);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Class 0 only, including a forced class bit
      applyStimulus(10'h255, 10'h000, 1'b1, 1'b1, 1'b0, 10'h255, 1'b1);
      applyStimulus(10'h355, 10'h000, 1'b1, 1'b1, 1'b0, 10'h255, 1'b1);
      applyStimulus(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);

      // Class 1 only
      applyStimulus(10'h000, 10'h201, 1'b1, 1'b0, 1'b1, 10'h301, 1'b1);
      applyStimulus(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);

      // Steady contention: four class-0 words then one class-1 word, twice
      for (int i = 0; i < 10; i++) begin
         if (cls_seq[i])
            w = 10'h380 + 10'(i);
         else
            w = 10'h210 + 10'(i);
         applyStimulus(10'h210 + 10'(i), 10'h280 + 10'(i), 1'b1,
                       !cls_seq[i], cls_seq[i], w, 1'b1);
      end
      applyStimulus(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);

      // Backpressure with a class-0 run of two already taken
      applyStimulus(10'h211, 10'h3C1, 1'b1, 1'b1, 1'b0, 10'h211, 1'b1);
      applyStimulus(10'h2AA, 10'h3C2, 1'b1, 1'b1, 1'b0, 10'h2AA, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(10'h2BB, 10'h3C3, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
         checkOutput("bp_hold", dataout, 10'h2AA);
      end
      applyStimulus(10'h2BB, 10'h3C3, 1'b1, 1'b1, 1'b0, 10'h2BB, 1'b1);
      applyStimulus(10'h2BC, 10'h3C4, 1'b1, 1'b1, 1'b0, 10'h2BC, 1'b1);
      applyStimulus(10'h2BD, 10'h3C5, 1'b1, 1'b0, 1'b1, 10'h3C5, 1'b1);
      applyStimulus(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);

`ifdef ARB_STATS_EN
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 17; i++)
         applyStimulus(10'h201, 10'h000, 1'b1, 1'b1, 1'b0, 10'h201, 1'b1);
      applyStimulus(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
      checkOutput("grant_cnt0_wrap", {6'd0, grant_cnt0}, 10'd1);
      checkOutput("grant_cnt1", {6'd0, grant_cnt1}, 10'd0);
`endif

      // Mid-cycle reset drops the held word and the pending pop at once
      applyStimulus(10'h2AA, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
      checkOutput("pre_reset_word", dataout, 10'h2AA);
      out_ready = 1'b1;
      #1;
      checkOutput("pre_reset_pop", {9'd0, pop_class0}, 10'd1);
      reset = 1'b1;
      #1;
      checkOutput("async_reset_dataout", dataout, 10'h000);
      checkOutput("async_reset_pops", {8'd0, pop_class0, pop_class1}, 10'h000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
      applyStimulus(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
      checkOutput("sb_drained", 10'(sb.size()), 10'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
